// File: rtl/pattern_sequencer.sv
// pattern_sequencer: steps through a window of a pattern memory at a
// programmable rate and presents one word per step. Each word is prefetched
// into a one-word buffer so that a step tick only has to copy the buffer.
// The pattern output is named sequence_o because "sequence" is a reserved
// word in SystemVerilog.
module pattern_sequencer #(
  parameter int WORD_SIZE      = 8,
  parameter int ADDRESS_SIZE   = 4,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [ADDRESS_SIZE-1:0]   start_addr,
  input  logic [ADDRESS_SIZE-1:0]   end_addr,
  input  logic [PRESCALE_WIDTH-1:0] step_div,
  input  logic [WORD_SIZE-1:0]      r_data,
  input  logic                      r_ready,
  output logic [ADDRESS_SIZE-1:0]   r_addr,
  output logic                      r_en,
  output logic [WORD_SIZE-1:0]      sequence_o,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_STEP, DONE} state_t;

  localparam logic [1:0]                MODE_ONESHOT  = 2'd1;
  localparam logic [1:0]                MODE_PINGPONG = 2'd2;
  localparam logic [ADDRESS_SIZE-1:0]   ADDR_ONE      = 1;
  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE       = 1;

  state_t                      state_q, state_d;
  logic [1:0]                  mode_q, mode_d;
  logic [ADDRESS_SIZE-1:0]     start_q, start_d, end_q, end_d, addr_q, addr_d;
  logic [PRESCALE_WIDTH-1:0]   div_q, div_d, cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]        buf_q, buf_d, seq_q, seq_d;
  logic                        buf_vld_q, buf_vld_d;
  logic                        under_q, under_d;
  logic                        first_q, first_d;  // first cycle of a read request
  logic                        dir_q, dir_d;      // ping-pong direction, 1 = up
  logic                        r_en_q, r_en_d, busy_q, busy_d, done_q, done_d;

  logic                        tick, accept, ping_pong;
  logic [ADDRESS_SIZE-1:0]     nxt_addr;
  logic                        nxt_dir;

  // Next-state logic: address walk, prefetch handshake, prescaler and flags.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    start_d   = start_q;
    end_d     = end_q;
    div_d     = div_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    seq_d     = seq_q;
    under_d   = under_q;
    first_d   = 1'b0;
    dir_d     = dir_q;

    tick   = (cnt_q == div_q);
    accept = (state_q == FETCH) && !first_q && r_ready;

    // Ping-pong only reverses on a real window; a reversed or one-word
    // window falls back to the loop walk.
    ping_pong = (mode_q == MODE_PINGPONG) && (start_q < end_q);
    nxt_dir   = dir_q;
    if (ping_pong) begin
      if (dir_q) begin
        if (addr_q == end_q) begin
          nxt_addr = addr_q - ADDR_ONE;
          nxt_dir  = 1'b0;
        end else begin
          nxt_addr = addr_q + ADDR_ONE;
        end
      end else begin
        if (addr_q == start_q) begin
          nxt_addr = addr_q + ADDR_ONE;
          nxt_dir  = 1'b1;
        end else begin
          nxt_addr = addr_q - ADDR_ONE;
        end
      end
    end else begin
      nxt_addr = (addr_q == end_q) ? start_q : addr_q + ADDR_ONE;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          mode_d    = mode;
          start_d   = start_addr;
          end_d     = end_addr;
          div_d     = step_div;
          addr_d    = start_addr;
          under_d   = 1'b0;
          dir_d     = 1'b1;
          buf_vld_d = 1'b0;
          first_d   = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        // A tick here has no word ready to present: flag it and drop it.
        if (tick) under_d = 1'b1;
        if (accept) begin
          buf_d     = r_data;
          buf_vld_d = 1'b1;
          state_d   = enable ? WAIT_STEP : IDLE;
        end
      end
      WAIT_STEP: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick && buf_vld_q) begin
          seq_d     = buf_q;
          buf_vld_d = 1'b0;
          if ((mode_q == MODE_ONESHOT) && (addr_q == end_q)) begin
            state_d = DONE;
          end else begin
            addr_d  = nxt_addr;
            dir_d   = nxt_dir;
            first_d = 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Prescaler free-runs only while staying busy; every start begins at 0.
    if ((state_q == FETCH || state_q == WAIT_STEP) &&
        (state_d == FETCH || state_d == WAIT_STEP))
      cnt_d = tick ? '0 : cnt_q + CNT_ONE;
    else
      cnt_d = '0;

    r_en_d = (state_d == FETCH);
    busy_d = (state_d == FETCH) || (state_d == WAIT_STEP);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset also kills any pending read at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      start_q   <= '0;
      end_q     <= '0;
      div_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      seq_q     <= '0;
      under_q   <= 1'b0;
      first_q   <= 1'b0;
      dir_q     <= 1'b1;
      r_en_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      start_q   <= start_d;
      end_q     <= end_d;
      div_q     <= div_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      seq_q     <= seq_d;
      under_q   <= under_d;
      first_q   <= first_d;
      dir_q     <= dir_d;
      r_en_q    <= r_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign r_addr     = addr_q;
  assign r_en       = r_en_q;
  assign sequence_o = seq_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = under_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios pinned with literal
// expectations, then randomized configuration, enable and memory latency,
// all checked every cycle against a behavioural model that precomputes the
// address visit order of the window.
module tb_pattern_sequencer;
  localparam int WS = 8;
  localparam int AS = 4;
  localparam int PW = 16;
  localparam int NA = 1 << AS;

  logic          clock = 1'b0;
  logic          reset, enable, r_ready, r_en, busy, done, underrun;
  logic [1:0]    mode;
  logic [AS-1:0] start_addr, end_addr, r_addr;
  logic [PW-1:0] step_div;
  logic [WS-1:0] r_data, sequence_o;
  logic [WS-1:0] mem [NA];

  always #5 clock = ~clock;
  assign r_data = mem[r_addr];

  pattern_sequencer #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .PRESCALE_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .start_addr(start_addr), .end_addr(end_addr), .step_div(step_div),
    .r_data(r_data), .r_ready(r_ready), .r_addr(r_addr), .r_en(r_en),
    .sequence_o(sequence_o), .busy(busy), .done(done), .underrun(underrun)
  );

  int n_vec = 0, n_err = 0, cyc = 0;

  // model: phase 0 idle, 1 fetching, 2 waiting for step, 3 finished
  int            m_phase, m_age, m_idx, m_cnt, m_div;
  bit            m_oneshot, m_under;
  int            ord[$];
  logic [WS-1:0] m_seq, m_buf;
  logic [AS-1:0] m_addr;

  int            rcnt, lat;
  bit            rand_lat;
  logic [WS-1:0] prev_seq;
  bit            prev_en;
  int            seq_log[$], seq_t[$], addr_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int sl(input int i);
    return (i < seq_log.size()) ? seq_log[i] : -1;
  endfunction
  function automatic int al(input int i);
    return (i < addr_log.size()) ? addr_log[i] : -1;
  endfunction
  function automatic int gap(input int i);
    return (i + 1 < seq_t.size()) ? seq_t[i+1] - seq_t[i] : -1;
  endfunction

  // Visit order of one pass over the window.
  task automatic build_order(input int s, input int e, input int md);
    ord.delete();
    if (md == 2 && s < e) begin
      for (int a = s; a <= e; a++) ord.push_back(a);
      for (int a = e - 1; a > s; a--) ord.push_back(a);
    end else begin
      for (int k = 0; k <= (e - s + NA) % NA; k++) ord.push_back((s + k) % NA);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_idx = 0; m_cnt = 0; m_div = 0;
    m_under = 1'b0; m_oneshot = 1'b0;
    m_seq = '0; m_buf = '0; m_addr = '0;
  endtask

  task automatic model_step();
    bit tick, busy_now;
    int nph;
    busy_now = (m_phase == 1 || m_phase == 2);
    tick     = busy_now && (m_cnt == m_div);
    nph      = m_phase;
    case (m_phase)
      0: if (enable) begin
        m_oneshot = (mode == 2'd1);
        m_div     = int'(step_div);
        build_order(int'(start_addr), int'(end_addr), int'(mode));
        m_idx = 0; m_addr = AS'(ord[0]); m_under = 1'b0; m_age = 0;
        nph = 1;
      end
      1: begin
        if (tick) m_under = 1'b1;
        if (m_age >= 1 && r_ready) begin
          m_buf = mem[m_addr];
          nph = enable ? 2 : 0;
        end
        m_age++;
      end
      2: if (!enable) nph = 0;
         else if (tick) begin
           m_seq = m_buf;
           if (m_oneshot && m_idx == ord.size() - 1) nph = 3;
           else begin
             m_idx = (m_idx + 1) % ord.size();
             m_addr = AS'(ord[m_idx]);
             m_age = 0;
             nph = 1;
           end
         end
      default: if (!enable) nph = 0;
    endcase
    m_cnt = (busy_now && (nph == 1 || nph == 2) && !tick) ? m_cnt + 1 : 0;
    m_phase = nph;
  endtask

  // One clock: model steps on the edge, outputs compared 1 time unit later,
  // then the memory responder decides r_ready for the next cycle.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    cyc++;
    chk("r_en",     32'(r_en),       32'(m_phase == 1));
    chk("busy",     32'(busy),       32'(m_phase == 1 || m_phase == 2));
    chk("done",     32'(done),       32'(m_phase == 3));
    chk("sequence", 32'(sequence_o), 32'(m_seq));
    chk("underrun", 32'(underrun),   32'(m_under));
    chk("r_addr",   32'(r_addr),     32'(m_addr));
    if (sequence_o !== prev_seq) begin
      seq_log.push_back(int'(sequence_o));
      seq_t.push_back(cyc);
    end
    prev_seq = sequence_o;
    if (r_en && !prev_en) addr_log.push_back(int'(r_addr));
    prev_en = r_en;
    if (r_en) begin
      rcnt++;
      r_ready = (rcnt >= lat);
    end else begin
      rcnt = 0;
      r_ready = 1'b0;
      if (rand_lat) lat = $urandom_range(1, 4);
    end
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    enable = 1'b0;
    #1;
    chk("rst r_en",     32'(r_en),       32'h0);
    chk("rst busy",     32'(busy),       32'h0);
    chk("rst done",     32'(done),       32'h0);
    chk("rst sequence", 32'(sequence_o), 32'h0);
    chk("rst underrun", 32'(underrun),   32'h0);
    chk("rst r_addr",   32'(r_addr),     32'h0);
    model_reset();
    rcnt = 0;
    r_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    prev_seq = '0;
    prev_en = 1'b0;
  endtask

  task automatic run_dir(input logic [1:0] md, input int s, input int e,
                         input int dv, input int lt, input int ncyc);
    do_reset();
    mode = md; start_addr = AS'(s); end_addr = AS'(e); step_div = PW'(dv);
    lat = lt; rand_lat = 1'b0;
    seq_log.delete(); seq_t.delete(); addr_log.delete();
    enable = 1'b1;
    repeat (ncyc) cycle();
  endtask

  initial begin
    int off;
    reset = 1'b0; enable = 1'b0; mode = '0; start_addr = '0; end_addr = '0;
    step_div = '0; r_ready = 1'b0; lat = 1; rand_lat = 1'b0; rcnt = 0;
    for (int a = 0; a < NA; a++) mem[a] = WS'(8'h40 + a);

    // loop 2..4, step every 10 clocks, memory ready on the 2nd r_en cycle
    run_dir(2'd0, 2, 4, 9, 2, 60);
    chk("loop w0", 32'(sl(0)), 32'h42);
    chk("loop w1", 32'(sl(1)), 32'h43);
    chk("loop w2", 32'(sl(2)), 32'h44);
    chk("loop w3", 32'(sl(3)), 32'h42);
    chk("loop gap0", 32'(gap(0)), 32'd10);
    chk("loop gap1", 32'(gap(1)), 32'd10);
    chk("loop gap2", 32'(gap(2)), 32'd10);
    chk("loop underrun", 32'(underrun), 32'h0);

    // one-shot 0..3 then finished
    run_dir(2'd1, 0, 3, 3, 1, 40);
    chk("oneshot w0", 32'(sl(0)), 32'h40);
    chk("oneshot w3", 32'(sl(3)), 32'h43);
    chk("oneshot words", 32'(seq_log.size()), 32'd4);
    chk("oneshot fetches", 32'(addr_log.size()), 32'd4);
    chk("oneshot done", 32'(done), 32'h1);
    chk("oneshot busy", 32'(busy), 32'h0);
    chk("oneshot r_en", 32'(r_en), 32'h0);

    // ping-pong 1..3
    run_dir(2'd2, 1, 3, 4, 2, 50);
    chk("pp w0", 32'(sl(0)), 32'h41);
    chk("pp w1", 32'(sl(1)), 32'h42);
    chk("pp w2", 32'(sl(2)), 32'h43);
    chk("pp w3", 32'(sl(3)), 32'h42);
    chk("pp w4", 32'(sl(4)), 32'h41);
    chk("pp w5", 32'(sl(5)), 32'h42);

    // loop wrapping through the top of the address space
    run_dir(2'd0, 14, 1, 3, 1, 30);
    chk("wrap a0", 32'(al(0)), 32'd14);
    chk("wrap a1", 32'(al(1)), 32'd15);
    chk("wrap a2", 32'(al(2)), 32'd0);
    chk("wrap a3", 32'(al(3)), 32'd1);
    chk("wrap a4", 32'(al(4)), 32'd14);

    // tick every clock against a slow memory
    run_dir(2'd0, 5, 7, 0, 3, 30);
    chk("under flag", 32'(underrun), 32'h1);
    chk("under w0", 32'(sl(0)), 32'h45);
    chk("under w1", 32'(sl(1)), 32'h46);
    chk("under w2", 32'(sl(2)), 32'h47);
    chk("under w3", 32'(sl(3)), 32'h45);

    // reset while a read is outstanding
    run_dir(2'd0, 3, 6, 5, 20, 4);
    chk("midread r_en", 32'(r_en), 32'h1);
    do_reset();
    repeat (5) cycle();
    chk("midread no refetch", 32'(r_en), 32'h0);

    // randomized configuration, enable drops and memory latency
    for (int a = 0; a < NA; a++) mem[a] = WS'($urandom);
    off = 0;
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      rand_lat = 1'b1;
      lat = $urandom_range(1, 4);
      for (int c = 0; c < 300; c++) begin
        mode       = 2'($urandom_range(0, 3));
        start_addr = AS'($urandom);
        end_addr   = AS'($urandom);
        step_div   = PW'($urandom_range(0, 6));
        if (off > 0) begin
          enable = 1'b0;
          off--;
        end else begin
          enable = 1'b1;
          if ($urandom_range(0, 59) == 0) off = $urandom_range(1, 3);
        end
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 8, width of r_data and sequence.
REQ-002 The block SHALL have parameter ADDRESS_SIZE, default 4, width of r_addr, start_addr and end_addr.
REQ-003 The block SHALL have parameter PRESCALE_WIDTH, default 16, width of step_div.
REQ-004 The block SHALL have port clock, input, 1, system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1, level: high runs the sequencer, low stops it.
REQ-007 The block SHALL have port mode, input, 2: 0 loop, 1 one-shot, 2 ping-pong, 3 treated as loop.
REQ-008 The block SHALL have ports start_addr and end_addr, input, ADDRESS_SIZE each, first and last pattern addresses.
REQ-009 The block SHALL have port step_div, input, PRESCALE_WIDTH, giving a step period of step_div+1 clocks.
REQ-010 The block SHALL have ports r_data (input, WORD_SIZE, memory read data) and r_ready (input, 1, memory ready).
REQ-011 The block SHALL have ports r_addr (output, ADDRESS_SIZE) and r_en (output, 1, read request).
REQ-012 The block SHALL have ports sequence (output, WORD_SIZE), busy, done and underrun (outputs, 1 each).

Function
REQ-013 The block SHALL implement states IDLE, FETCH, WAIT_STEP and DONE.
REQ-014 In IDLE with enable high, the block SHALL latch mode, start_addr, end_addr and step_div, set the address to start_addr, clear the prescaler and underrun, and enter FETCH.
REQ-015 In FETCH, r_en SHALL be high and r_addr SHALL be held stable until the read is accepted.
REQ-016 r_ready SHALL be ignored in the first cycle of r_en; a read SHALL be accepted on the first later edge with r_ready high, capturing r_data into a one-word prefetch buffer.
REQ-017 r_en SHALL be low in the cycle after acceptance; acceptance SHALL move FETCH to WAIT_STEP.
REQ-018 The prescaler SHALL count 0..step_div while busy and pulse a step tick when it equals step_div; step_div=0 SHALL give a tick every clock.
REQ-019 On a tick in WAIT_STEP, sequence SHALL load the buffer, the address SHALL advance, and the state SHALL go to FETCH, or to DONE under REQ-021.
REQ-020 Loop mode: the address SHALL increment modulo 2^ADDRESS_SIZE; from end_addr it SHALL return to start_addr. start_addr>end_addr SHALL wrap through the maximum address.
REQ-021 One-shot mode: after presenting the end_addr word, the block SHALL enter DONE with no further fetch.
REQ-022 Ping-pong mode: the direction SHALL reverse at each endpoint without repeating the endpoint word. start_addr>end_addr SHALL behave as loop.
REQ-023 start_addr==end_addr SHALL repeat that one word (loop/ping-pong) or present it once (one-shot).
REQ-024 A tick arriving in FETCH SHALL set the sticky underrun flag, be dropped, and leave sequence unchanged.
REQ-025 enable low SHALL return the block to IDLE: immediately from WAIT_STEP or DONE; from FETCH only after the pending read is accepted. sequence SHALL hold its value.
REQ-026 busy SHALL be high in FETCH and WAIT_STEP; done SHALL be high only in DONE.
REQ-027 DONE SHALL be left only via enable low; a restart SHALL require enable low then high.
REQ-028 Configuration input changes while busy SHALL have no effect until the next start.

Reset
REQ-029 Reset SHALL force IDLE, prescaler 0, buffer invalid, sequence 0, r_addr 0, r_en 0, busy 0, done 0, underrun 0.
REQ-030 Reset asserted mid-read SHALL drop r_en asynchronously and discard the pending read.

Verification
REQ-031 Loop, start=2, end=4, step_div=9, memory ready 2 clocks after r_en -> sequence M[2],M[3],M[4],M[2]... at 10-clock spacing, underrun 0.
REQ-032 One-shot, start=0, end=3 -> sequence M[0]..M[3], then done=1, busy=0, r_en stays 0.
REQ-033 Ping-pong, start=1, end=3 -> sequence M[1],M[2],M[3],M[2],M[1],M[2].
REQ-034 Loop, start=14, end=1, ADDRESS_SIZE=4 -> r_addr 14,15,0,1,14.
REQ-035 step_div=0 with r_ready delayed 3 clocks -> underrun=1, sequence changes only on accepted words.
REQ-036 Reset pulse while r_en is high -> r_en=0 and all outputs at reset values before the next clock edge.
